rr_arbiter_wrr: RTL and testbench
=================================

# rr_arbiter_wrr

Parametrised two-level weighted round-robin arbiter with a registered one-hot grant. It is the successor to the fixed 32-input hierarchical round-robin arbiter. It is generalised in requester count and group size, and adds per-requester burst weights, so a winner can hold the grant for up to its weight in consecutive cycles. It sits between the decoder's per-lane request sources and the shared Forney evaluation datapath.

## Interface
- REQ_NB, 32: number of requesters; must be a multiple of GRP_SZ.
- GRP_SZ, 8: requesters per group; power of two, at least 2. Number of groups G = REQ_NB/GRP_SZ, G ≥ 1.
- WGT_W, 4: weight width; maximum burst length is 2^WGT_W−1.
- clk_i  in  1  clock; single clock domain.
- rst_i  in  1  asynchronous, active-high reset.
- srst_i  in  1  synchronous clear; priority over en_i.
- en_i  in  1  arbitration enable; 0 freezes all state and outputs.
- req_i  in  REQ_NB  request vector, level-sensitive.
- weight_i  in  REQ_NB*WGT_W  per-requester weight; slice k is bits [k*WGT_W +: WGT_W]. A weight of 0 is treated as 1.
- grant_o  out  REQ_NB  registered one-hot grant, or all zeros.
- grant_idx_o  out  $clog2(REQ_NB)  index of the granted requester; 0 when grant_vld_o=0.
- grant_vld_o  out  1  grant_o is non-zero.
- burst_last_o  out  1  current grant cycle is the last one its credit allows.

## Operation
- **State:**
  - cur_vld, cur_idx, credit (WGT_W bits).
  - gptr: group pointer, $clog2(G) bits, or 0 when G=1.
  - iptr[G]: per-group inner pointer, $clog2(GRP_SZ) bits each.
- **Reset:** rst_i or srst_i clears every state bit to 0. All outputs are 0.
- **en_i=0:** state and outputs hold unchanged, including an active grant whose request has since dropped.
- **Per clock edge with en_i=1 and no srst_i:**
  - **Continue:** if cur_vld, req_i[cur_idx]=1 and credit≠0, the grant is kept and credit decrements by 1.
  - **Release:** otherwise, if cur_vld, compute next pointers. For g=cur_idx/GRP_SZ: gptr'=(g+1) mod G, and iptr'[g]=(cur_idx+1) mod GRP_SZ (local index). Other iptr are unchanged.
  - **Arbitrate:** this happens in the same edge as a release (no bubble cycle), or when cur_vld=0 with gptr'=gptr.
    - Pick the first group with any request, searching cyclically from gptr'.
    - Within that group, pick the first requesting local index, searching cyclically from iptr'[g].
    - On a winner k: cur_vld=1, cur_idx=k, credit=eff_w(k)−1, where eff_w = max(weight_i[k], 1) is sampled at this edge only.
    - The pointers commit to gptr'/iptr'.
  - **No requests:** cur_vld=0 and the pointers commit to gptr'/iptr'.
- **Outputs:** decoded directly from registers.
  - grant_o = cur_vld ? onehot(cur_idx) : 0.
  - burst_last_o = cur_vld && credit==0.
- **Weight changes:** a change to weight_i during a burst has no effect until that requester's next win.
- **Early release:** a requester that drops req mid-burst loses the grant at the next edge. Its pointers advance as for a normal release.
- **Guarantee:** any requester held high is granted within (REQ_NB−1)·(2^WGT_W−1)+1 cycles.

## Timing
- Latency: a req_i edge sampled at clock edge t gives grant_o valid right after edge t. The bench sees it one cycle after driving.
- grant_o changes only on a clk_i rising edge (register outputs, no glitches).
- A burst of weight w occupies exactly w consecutive cycles if the request is held. burst_last_o is high in cycle w.
- Back-to-back: the next winner's grant starts the cycle after the last burst cycle, with no idle cycle.
- rst_i asserted mid-burst: outputs go to 0 immediately and asynchronously. After release, arbitration restarts from gptr=0, iptr=0.
- srst_i and en_i=0 in the same cycle: srst_i wins.

## Test plan
- Walk a single req bit through 0..REQ_NB−1 with weight 1. Required: grant_o==onehot(i), grant_idx_o==i, burst_last_o=1 one cycle after each req is driven.
- req[3] and req[6], weights 1/1, for 64 cycles. Required: alternating 3,6,3,6…; count 32/32.
- Same requesters with weight[3]=3 and weight[6]=0 (treated as 1). Required: repeating 3,3,3,6; counts 48/16; burst_last_o high on the third 3 and on every 6.
- req {0,1,8} after reset, weights 1. Required: grant order 0,8,1,8,0,8,1…; req {2,12,20,28} gives order 2,12,20,28 repeating; each count 16 over 64 cycles.
- weight[5]=7, hold req[5], drop it in burst cycle 3, with req[9] pending. Required: grant[5] for 3 cycles, then grant[9] on the next edge with no bubble.
- Mid-burst en_i=0 for 5 cycles: grant is frozen and credit does not decrement. Then pulse rst_i asynchronously: all outputs are 0 immediately; after release with req {1,2}, the first grant goes to 1.
- Throughout, random 25% request traffic with random weights for 2000 cycles. Required: one-hot-or-zero on every cycle, and no requester waits longer than the starvation bound.

Source files
------------

// File: rtl/rr_arbiter_wrr.sv
// rr_arbiter_wrr: two-level weighted round-robin arbiter with a registered
// one-hot grant. Requesters are split into groups of GRP_SZ; a group pointer
// rotates across groups and a per-group inner pointer rotates within each
// group. A winner keeps the grant for up to max(weight,1) consecutive cycles
// while its request stays high.
//
// Ports:
//   clk_i        clock
//   rst_i        asynchronous active-high reset
//   srst_i       synchronous clear, wins over en_i
//   en_i         arbitration enable; 0 holds all state and outputs
//   req_i        level-sensitive request vector
//   weight_i     per-requester burst weight, slice k at [k*WGT_W +: WGT_W]
//   grant_o      registered one-hot grant (or zero)
//   grant_idx_o  index of the granted requester, 0 when nothing is granted
//   grant_vld_o  a grant is active
//   burst_last_o the current grant cycle is the last one its credit allows
module rr_arbiter_wrr #(
    parameter int unsigned REQ_NB = 32,
    parameter int unsigned GRP_SZ = 8,
    parameter int unsigned WGT_W  = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      srst_i,
    input  logic                      en_i,
    input  logic [REQ_NB-1:0]         req_i,
    input  logic [REQ_NB*WGT_W-1:0]   weight_i,
    output logic [REQ_NB-1:0]         grant_o,
    output logic [$clog2(REQ_NB)-1:0] grant_idx_o,
    output logic                      grant_vld_o,
    output logic                      burst_last_o
);

    localparam int unsigned NGRP  = REQ_NB / GRP_SZ;
    localparam int unsigned IDX_W = $clog2(REQ_NB);
    localparam int unsigned LOC_W = $clog2(GRP_SZ);
    // A single group still gets a 1-bit pointer register, held at 0.
    localparam int unsigned GPT_W = (NGRP > 1) ? $clog2(NGRP) : 1;

    // Registered state
    logic                    cur_vld_q;
    logic [IDX_W-1:0]        cur_idx_q;
    logic [WGT_W-1:0]        credit_q;
    logic [GPT_W-1:0]        gptr_q;
    logic [NGRP*LOC_W-1:0]   iptr_q;
    logic [REQ_NB-1:0]       grant_q;
    logic                    last_q;

    // Next-state values
    logic                    cur_vld_d;
    logic [IDX_W-1:0]        cur_idx_d;
    logic [WGT_W-1:0]        credit_d;
    logic [GPT_W-1:0]        gptr_d;
    logic [NGRP*LOC_W-1:0]   iptr_d;
    logic [REQ_NB-1:0]       grant_d;
    logic                    last_d;

    // Arbitration intermediates
    logic                    keep_c;
    logic [GPT_W-1:0]        gptr_nx;
    logic [NGRP*LOC_W-1:0]   iptr_nx;
    logic                    win_vld;
    logic [IDX_W-1:0]        win_idx;
    logic [WGT_W-1:0]        win_wgt;
    int unsigned             cur_grp;
    int unsigned             cur_loc;
    int unsigned             grp;
    int unsigned             loc;

    // Pointer advance on release and the two-level cyclic search.
    always_comb begin
        keep_c  = cur_vld_q && req_i[cur_idx_q] && (credit_q != '0);
        cur_grp = 32'(cur_idx_q) / GRP_SZ;
        cur_loc = 32'(cur_idx_q) % GRP_SZ;

        // Pointers only move past a grant that is being released; with no
        // active grant the search starts from the committed pointers.
        gptr_nx = gptr_q;
        iptr_nx = iptr_q;
        if (cur_vld_q) begin
            gptr_nx = GPT_W'((cur_grp + 1) % NGRP);
            iptr_nx[cur_grp*LOC_W +: LOC_W] = LOC_W'((cur_loc + 1) % GRP_SZ);
        end

        win_vld = 1'b0;
        win_idx = '0;
        win_wgt = '0;
        grp     = 0;
        loc     = 0;
        for (int unsigned o = 0; o < NGRP; o++) begin
            grp = (32'(gptr_nx) + o) % NGRP;
            if (!win_vld && (req_i[grp*GRP_SZ +: GRP_SZ] != '0)) begin
                for (int unsigned j = 0; j < GRP_SZ; j++) begin
                    loc = (32'(iptr_nx[grp*LOC_W +: LOC_W]) + j) % GRP_SZ;
                    if (!win_vld && (req_i[grp*GRP_SZ + loc +: 1] != 1'b0)) begin
                        win_vld = 1'b1;
                        win_idx = IDX_W'(grp*GRP_SZ + loc);
                        win_wgt = weight_i[(grp*GRP_SZ + loc)*WGT_W +: WGT_W];
                    end
                end
            end
        end
    end

    // Next-state selection: continue the burst or re-arbitrate.
    always_comb begin
        cur_vld_d = cur_vld_q;
        cur_idx_d = cur_idx_q;
        credit_d  = credit_q;
        gptr_d    = gptr_q;
        iptr_d    = iptr_q;
        grant_d   = grant_q;
        last_d    = last_q;

        if (keep_c) begin
            credit_d = credit_q - WGT_W'(1);
            last_d   = (credit_q == WGT_W'(1));
        end else begin
            gptr_d    = gptr_nx;
            iptr_d    = iptr_nx;
            cur_vld_d = win_vld;
            cur_idx_d = win_idx;
            // Weight 0 behaves as 1, i.e. a single-cycle burst.
            credit_d  = (win_wgt == '0) ? '0 : (win_wgt - WGT_W'(1));
            grant_d   = win_vld ? (REQ_NB'(1) << win_idx) : '0;
            last_d    = win_vld && (win_wgt <= WGT_W'(1));
        end
    end

    // State registers; srst_i takes priority over en_i.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cur_vld_q <= 1'b0;
            cur_idx_q <= '0;
            credit_q  <= '0;
            gptr_q    <= '0;
            iptr_q    <= '0;
            grant_q   <= '0;
            last_q    <= 1'b0;
        end else if (srst_i) begin
            cur_vld_q <= 1'b0;
            cur_idx_q <= '0;
            credit_q  <= '0;
            gptr_q    <= '0;
            iptr_q    <= '0;
            grant_q   <= '0;
            last_q    <= 1'b0;
        end else if (en_i) begin
            cur_vld_q <= cur_vld_d;
            cur_idx_q <= cur_idx_d;
            credit_q  <= credit_d;
            gptr_q    <= gptr_d;
            iptr_q    <= iptr_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
        end
    end

    assign grant_o      = grant_q;
    assign grant_idx_o  = cur_idx_q;
    assign grant_vld_o  = cur_vld_q;
    assign burst_last_o = last_q;

endmodule

// File: tb/tb_rr_arbiter_wrr.sv
// Self-checking bench for rr_arbiter_wrr: directed vector table, hand-written
// multi-cycle sequences, and randomized traffic against a rank-based model.
module tb_rr_arbiter_wrr;

    localparam int unsigned N     = 32;
    localparam int unsigned GS    = 8;
    localparam int unsigned WW    = 4;
    localparam int unsigned NG    = N / GS;
    localparam int unsigned IW    = $clog2(N);
    localparam int unsigned BOUND = (N - 1) * ((1 << WW) - 1) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          srst;
    logic          en;
    logic [N-1:0]  req;
    logic [N*WW-1:0] wgt;
    logic [N-1:0]  grant;
    logic [IW-1:0] gidx;
    logic          gvld;
    logic          blast;

    int passed = 0;
    int total  = 0;

    // Reference model state: current owner, cycles used in the burst,
    // effective weight of the burst, and the round-robin pointers.
    int m_cur;
    int m_used;
    int m_w;
    int m_gptr;
    int m_iptr [NG];

    always #5 clk = ~clk;

    rr_arbiter_wrr #(.REQ_NB(N), .GRP_SZ(GS), .WGT_W(WW)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .srst_i       (srst),
        .en_i         (en),
        .req_i        (req),
        .weight_i     (wgt),
        .grant_o      (grant),
        .grant_idx_o  (gidx),
        .grant_vld_o  (gvld),
        .burst_last_o (blast)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    function automatic void model_reset();
        m_cur  = -1;
        m_used = 0;
        m_w    = 0;
        m_gptr = 0;
        for (int g = 0; g < NG; g++) m_iptr[g] = 0;
    endfunction

    // One clock edge of the arbiter described as: keep while credit lasts,
    // otherwise advance pointers past the owner and pick the requester with
    // the smallest (group distance, local distance) rank.
    function automatic void model_step();
        int best;
        int bestkey;
        int key;
        int g;
        int l;
        int w;
        if (srst) begin
            model_reset();
            return;
        end
        if (!en) return;
        if (m_cur >= 0 && req[m_cur] && m_used < m_w) begin
            m_used++;
            return;
        end
        if (m_cur >= 0) begin
            m_gptr = (m_cur / GS + 1) % NG;
            m_iptr[m_cur / GS] = (m_cur % GS + 1) % GS;
        end
        best    = -1;
        bestkey = N + 1;
        for (int k = 0; k < N; k++) begin
            if (req[k]) begin
                g   = k / GS;
                l   = k % GS;
                key = ((g + NG - m_gptr) % NG) * GS + ((l + GS - m_iptr[g]) % GS);
                if (key < bestkey) begin
                    bestkey = key;
                    best    = k;
                end
            end
        end
        if (best >= 0) begin
            w      = int'(wgt[best*WW +: WW]);
            m_cur  = best;
            m_w    = (w == 0) ? 1 : w;
            m_used = 1;
        end else begin
            m_cur = -1;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        srst = 1'b0;
        en   = 1'b1;
        req  = '0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic set_all_w(input int w);
        for (int k = 0; k < N; k++) wgt[k*WW +: WW] = WW'(w);
    endtask

    task automatic check_model(input string tag);
        logic [N-1:0] eg;
        eg = '0;
        if (m_cur >= 0) eg[m_cur] = 1'b1;
        check({tag, "_grant"}, 64'(grant), 64'(eg));
        check({tag, "_idx"},   64'(gidx),  (m_cur >= 0) ? 64'(m_cur) : 64'(0));
        check({tag, "_vld"},   64'(gvld),  64'(m_cur >= 0));
        check({tag, "_last"},  64'(blast), 64'(m_cur >= 0 && m_used == m_w));
    endtask

    typedef struct {
        logic [N-1:0]  req;
        logic [WW-1:0] w;
        int            idx;
        bit            vld;
        bit            last;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic [N-1:0] r;
        logic [N-1:0] eg;
        logic [N-1:0] pending;
        int c_a;
        int c_b;
        int c_c;
        int c_d;
        int bad;
        int ord[4];
        int waitc[N];
        int max_wait;

        rst  = 1'b1;
        srst = 1'b0;
        en   = 1'b1;
        req  = '0;
        wgt  = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        check("reset_grant", 64'(grant), 64'(0));
        check("reset_idx",   64'(gidx),  64'(0));
        check("reset_vld",   64'(gvld),  64'(0));
        check("reset_last",  64'(blast), 64'(0));

        // Directed vector table
        for (int i = 0; i < N; i++) begin
            r = '0;
            r[i] = 1'b1;
            vecs.push_back('{r, WW'(1), i, 1'b1, 1'b1});
        end
        vecs.push_back('{'0, WW'(1), 0, 1'b0, 1'b0});
        r = '0; r[17] = 1'b1;
        vecs.push_back('{r, WW'(2), 17, 1'b1, 1'b0});
        vecs.push_back('{r, WW'(2), 17, 1'b1, 1'b1});
        vecs.push_back('{'0, WW'(2), 0, 1'b0, 1'b0});
        r = '0; r[4] = 1'b1;
        vecs.push_back('{r, WW'(0), 4, 1'b1, 1'b1});
        vecs.push_back('{'0, WW'(0), 0, 1'b0, 1'b0});

        for (int v = 0; v < vecs.size(); v++) begin
            req = vecs[v].req;
            set_all_w(int'(vecs[v].w));
            tick();
            eg = '0;
            if (vecs[v].vld) eg[vecs[v].idx] = 1'b1;
            check($sformatf("vec%0d_grant", v), 64'(grant), 64'(eg));
            check($sformatf("vec%0d_idx", v),   64'(gidx),  64'(vecs[v].idx));
            check($sformatf("vec%0d_vld", v),   64'(gvld),  64'(vecs[v].vld));
            check($sformatf("vec%0d_last", v),  64'(blast), 64'(vecs[v].last));
        end

        // Two requesters, weight 1: strict alternation 3,6
        do_reset();
        set_all_w(1);
        req = '0; req[3] = 1'b1; req[6] = 1'b1;
        c_a = 0; c_b = 0; bad = 0;
        for (int c = 0; c < 64; c++) begin
            tick();
            if (gvld && gidx == IW'(3)) c_a++;
            if (gvld && gidx == IW'(6)) c_b++;
            if (!gvld || gidx != IW'((c % 2 == 0) ? 3 : 6) || !blast) bad++;
        end
        check("alt_cnt3", 64'(c_a), 64'(32));
        check("alt_cnt6", 64'(c_b), 64'(32));
        check("alt_order", 64'(bad), 64'(0));

        // Weights 3 and 0: pattern 3,3,3,6
        do_reset();
        set_all_w(1);
        wgt[3*WW +: WW] = WW'(3);
        wgt[6*WW +: WW] = WW'(0);
        req = '0; req[3] = 1'b1; req[6] = 1'b1;
        c_a = 0; c_b = 0; bad = 0;
        for (int c = 0; c < 64; c++) begin
            tick();
            if (gvld && gidx == IW'(3)) c_a++;
            if (gvld && gidx == IW'(6)) c_b++;
            if (gidx != IW'((c % 4 < 3) ? 3 : 6) || blast != (c % 4 >= 2)) bad++;
        end
        check("wgt_cnt3", 64'(c_a), 64'(48));
        check("wgt_cnt6", 64'(c_b), 64'(16));
        check("wgt_pattern", 64'(bad), 64'(0));

        // Cross-group fairness: {0,1,8}
        do_reset();
        set_all_w(1);
        req = '0; req[0] = 1'b1; req[1] = 1'b1; req[8] = 1'b1;
        ord[0] = 0; ord[1] = 8; ord[2] = 1; ord[3] = 8;
        bad = 0;
        for (int c = 0; c < 64; c++) begin
            tick();
            if (!gvld || gidx != IW'(ord[c % 4])) bad++;
        end
        check("grp_order_018", 64'(bad), 64'(0));

        // One requester per group: {2,12,20,28}
        do_reset();
        req = '0; req[2] = 1'b1; req[12] = 1'b1; req[20] = 1'b1; req[28] = 1'b1;
        ord[0] = 2; ord[1] = 12; ord[2] = 20; ord[3] = 28;
        bad = 0; c_a = 0; c_b = 0; c_c = 0; c_d = 0;
        for (int c = 0; c < 64; c++) begin
            tick();
            if (!gvld || gidx != IW'(ord[c % 4])) bad++;
            if (gidx == IW'(2))  c_a++;
            if (gidx == IW'(12)) c_b++;
            if (gidx == IW'(20)) c_c++;
            if (gidx == IW'(28)) c_d++;
        end
        check("grp_order_4", 64'(bad), 64'(0));
        check("grp_cnt2",  64'(c_a), 64'(16));
        check("grp_cnt12", 64'(c_b), 64'(16));
        check("grp_cnt20", 64'(c_c), 64'(16));
        check("grp_cnt28", 64'(c_d), 64'(16));

        // Early release: req[5] weight 7 dropped in burst cycle 3, req[9] pending
        do_reset();
        set_all_w(1);
        wgt[5*WW +: WW] = WW'(7);
        req = '0; req[5] = 1'b1; req[9] = 1'b1;
        bad = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (grant != (N'(1) << 5) || blast) bad++;
        end
        check("early_burst5", 64'(bad), 64'(0));
        req[5] = 1'b0;
        tick();
        check("early_next_idx", 64'(gidx), 64'(9));
        check("early_next_vld", 64'(gvld), 64'(1));

        // Enable freeze mid-burst, then srst over en=0, then async reset
        do_reset();
        set_all_w(1);
        wgt[5*WW +: WW] = WW'(7);
        req = '0; req[5] = 1'b1;
        tick();
        tick();
        check("frz_pre_idx", 64'(gidx), 64'(5));
        en = 1'b0;
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (grant != (N'(1) << 5) || blast || !gvld) bad++;
        end
        check("frz_hold", 64'(bad), 64'(0));
        en = 1'b1;
        bad = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (grant != (N'(1) << 5) || blast) bad++;
        end
        tick();
        check("frz_resume", 64'(bad), 64'(0));
        check("frz_last", 64'(blast), 64'(1));
        check("frz_last_idx", 64'(gidx), 64'(5));

        srst = 1'b1;
        en   = 1'b0;
        tick();
        check("srst_grant", 64'(grant), 64'(0));
        check("srst_vld", 64'(gvld), 64'(0));
        srst = 1'b0;
        en   = 1'b1;
        tick();
        tick();
        check("pre_rst_idx", 64'(gidx), 64'(5));
        #2;
        rst = 1'b1;
        #1;
        check("arst_grant", 64'(grant), 64'(0));
        check("arst_idx",   64'(gidx),  64'(0));
        check("arst_vld",   64'(gvld),  64'(0));
        check("arst_last",  64'(blast), 64'(0));
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        set_all_w(1);
        req = '0; req[1] = 1'b1; req[2] = 1'b1;
        tick();
        check("arst_first_idx", 64'(gidx), 64'(1));

        // Randomized traffic against the model with a starvation watch
        do_reset();
        for (int k = 0; k < N; k++) waitc[k] = 0;
        max_wait = 0;
        pending  = '0;
        wgt = {$urandom(), $urandom(), $urandom(), $urandom()};
        for (int c = 0; c < 2000; c++) begin
            req = ($urandom() & $urandom()) | pending;
            if ($urandom_range(0, 7) == 0) wgt = {$urandom(), $urandom(), $urandom(), $urandom()};
            en   = ($urandom_range(0, 19) != 0);
            srst = ($urandom_range(0, 199) == 0);
            tick();
            check_model($sformatf("rnd%0d", c));
            check($sformatf("rnd%0d_onehot0", c), 64'($onehot0(grant)), 64'(1));
            for (int k = 0; k < N; k++) begin
                if (srst || grant[k] || !req[k]) waitc[k] = 0;
                else if (en) waitc[k]++;
                if (waitc[k] > max_wait) max_wait = waitc[k];
            end
            pending = srst ? '0 : (req & ~grant);
        end
        srst = 1'b0;
        en   = 1'b1;
        check("rnd_starvation", 64'(max_wait <= BOUND), 64'(1));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
